// File: rtl/axis_arb_pkg.sv
// Shared types and default sizing for the weighted round-robin AXI-Stream arbiter.
// Zero latency (declarations only); no flow control of its own.
package axis_arb_pkg;
  localparam int N_DEF  = 4;
  localparam int DW_DEF = 8;
  localparam int WW_DEF = 4;
  localparam int IW_DEF = $clog2(N_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;
endpackage

// File: rtl/rr_picker.sv
// Rotating priority encoder: first set req at or above ptr, wrapping N-1 to 0.
// Purely combinational, zero latency; no backpressure.
module rr_picker
  import axis_arb_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  // Scan offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    any = |req;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/axis_wrr_arbiter.sv
// Packet-atomic weighted round-robin merge of N AXI-Stream sources onto one sink.
// One-cycle arbitration bubble per packet, zero-latency data path; sink tready passes straight to the granted source.
module axis_wrr_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int N  = N_DEF,
  parameter  int DW = DW_DEF,
  parameter  int WW = WW_DEF,
  localparam int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    s_tvalid,
  input  logic [N-1:0]    s_tlast,
  input  logic [N*DW-1:0] s_tdata,
  output logic [N-1:0]    s_tready,
  input  logic [N*WW-1:0] weight,
  output logic            m_tvalid,
  output logic            m_tlast,
  output logic [DW-1:0]   m_tdata,
  input  logic            m_tready,
  output logic [IW-1:0]   grant_id,
  output logic            busy
);

  state_t        state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt, grant_nxt;
  logic [WW-1:0] credit, credit_nxt, w_pick;
  logic          pick_any;
  logic [IW-1:0] pick_idx;
  logic          hold;
  logic          eop;

  rr_picker #(.N(N), .IW(IW)) u_picker (
    .req (s_tvalid),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign w_pick = weight[pick_idx*WW +: WW];
  // Remaining quota keeps the turn with the current source if it is still asking.
  assign hold   = (credit != '0) && s_tvalid[grant_id];
  assign eop    = (state == PKT) && m_tvalid && m_tready && m_tlast;
  assign busy   = (state == PKT);

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    credit_nxt = credit;
    grant_nxt  = grant_id;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = PKT;
          if (!hold) begin
            grant_nxt  = pick_idx;
            credit_nxt = (w_pick == '0) ? WW'(1) : w_pick;
          end
        end
      end
      PKT: begin
        if (eop) begin
          state_nxt  = IDLE;
          credit_nxt = credit - WW'(1);
          if (credit == WW'(1)) begin
            ptr_nxt = (grant_id == IW'(N - 1)) ? '0 : grant_id + IW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      credit   <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      credit   <= credit_nxt;
      grant_id <= grant_nxt;
    end
  end

  always_comb begin
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tdata  = '0;
    s_tready = '0;
    if (state == PKT) begin
      m_tvalid           = s_tvalid[grant_id];
      m_tlast            = s_tlast[grant_id];
      m_tdata            = s_tdata[grant_id*DW +: DW];
      s_tready[grant_id] = m_tready;
    end
  end

endmodule

// File: tb/tb_axis_wrr_arbiter.sv
// Randomized bench for axis_wrr_arbiter: packet-level reference model feeds a beat scoreboard.
module tb_axis_wrr_arbiter;
  localparam int N = 4, DW = 8, WW = 4, IW = 2, DEPTH = 256;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    s_tvalid = '0;
  logic [N-1:0]    s_tlast = '0;
  logic [N*DW-1:0] s_tdata = '0;
  logic [N-1:0]    s_tready;
  logic [N*WW-1:0] weight = '0;
  logic            m_tvalid, m_tlast;
  logic [DW-1:0]   m_tdata;
  logic            m_tready = 1'b0;
  logic [IW-1:0]   grant_id;
  logic            busy;

  always #5 clk = ~clk;

  axis_wrr_arbiter #(.N(N), .DW(DW), .WW(WW)) dut (
    .clk(clk), .reset(reset),
    .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tdata(s_tdata), .s_tready(s_tready),
    .weight(weight),
    .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tdata(m_tdata), .m_tready(m_tready),
    .grant_id(grant_id), .busy(busy)
  );

  // Per-source packet store: {last, data} per beat, head/tail are free-running.
  logic [DW:0] beats [N][DEPTH];
  int head [N];
  int tail [N];

  int checks = 0;
  int errors = 0;

  bit m_busy = 0;
  int m_g = 0, m_ptr = 0, m_credit = 0;
  logic [IW+DW:0] exp_q[$];

  int gate_pct = 100, rdy_pct = 100;
  bit force_all = 0;
  int log_g [64];
  int log_n = 0;
  bit first = 1;
  int beats_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (head[i] != tail[i]) return 1;
    return 0;
  endfunction

  task automatic add_pkt(input int s, input int len, input int fixed);
    for (int b = 0; b < len; b++) begin
      logic [DW-1:0] d;
      d = (fixed >= 0) ? DW'(fixed) : DW'($urandom_range(255));
      beats[s][tail[s] % DEPTH] = {(b == len - 1), d};
      tail[s]++;
    end
  endtask

  // Reference model: packet-granular WRR decisions from the arbitration rules.
  always @(posedge clk) begin
    logic [DW:0] b;
    if (reset) begin
      m_busy = 0; m_g = 0; m_ptr = 0; m_credit = 0; first = 1;
      for (int i = 0; i < N; i++) head[i] = tail[i];
      exp_q.delete();
    end else if (!m_busy) begin
      if (s_tvalid != '0) begin
        if (!(m_credit > 0 && s_tvalid[m_g])) begin
          int w;
          w = -1;
          for (int k = 0; k < N; k++)
            if (w < 0 && s_tvalid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
          m_g = w;
          m_credit = int'(weight[m_g*WW +: WW]);
          if (m_credit == 0) m_credit = 1;
        end
        m_busy = 1;
        for (int h = head[m_g]; h < tail[m_g]; h++) begin
          b = beats[m_g][h % DEPTH];
          exp_q.push_back({IW'(m_g), b});
          if (b[DW]) break;
        end
      end
    end else if (m_tready && s_tvalid[m_g]) begin
      b = beats[m_g][head[m_g] % DEPTH];
      head[m_g]++;
      if (b[DW]) begin
        m_credit--;
        if (m_credit == 0) m_ptr = (m_g + 1) % N;
        m_busy = 0;
      end
    end
  end

  // Source and sink drivers, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      bit on;
      on = (head[i] != tail[i]) && ($urandom_range(99) < gate_pct);
      s_tvalid[i] = force_all || on;
      if (head[i] != tail[i]) begin
        s_tlast[i]          = beats[i][head[i] % DEPTH][DW];
        s_tdata[i*DW +: DW] = beats[i][head[i] % DEPTH][DW-1:0];
      end else begin
        s_tlast[i]          = 1'b0;
        s_tdata[i*DW +: DW] = '0;
      end
    end
    m_tready = ($urandom_range(99) < rdy_pct);
  end

  // Monitor: control outputs every cycle, data beats against the scoreboard.
  always @(negedge clk) begin
    logic [N-1:0] er;
    logic [IW+DW:0] e;
    er = m_busy ? (N'(m_tready) << m_g) : '0;
    chk("busy", int'(busy), int'(m_busy));
    chk("s_tready", int'(s_tready), int'(er));
    chk("m_tvalid", int'(m_tvalid), int'(m_busy && s_tvalid[m_g]));
    chk("grant_id", int'(grant_id), m_g);
    if (!m_busy) chk("idle_data", int'({m_tlast, m_tdata}), 0);
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        chk("beat_unexpected", int'({grant_id, m_tlast, m_tdata}), -1);
      end else begin
        e = exp_q.pop_front();
        chk("beat", int'({grant_id, m_tlast, m_tdata}), int'(e));
      end
      beats_seen++;
      if (first && log_n < 64) begin
        log_g[log_n] = int'(grant_id);
        log_n++;
      end
      first = m_tlast;
    end
  end

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    beats_seen = 0;
    log_n = 0;
    for (int i = 0; i < 64; i++) log_g[i] = -1;
  endtask

  task automatic drain(input string name, input int budget);
    int c;
    c = 0;
    while ((pending() || exp_q.size() != 0 || m_busy) && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (c >= budget) chk({name, "_timeout"}, c, 0);
  endtask

  initial begin
    int exp_rr [5];
    int exp_w [8];
    int c;
    exp_rr = '{0, 1, 2, 3, 0};
    exp_w  = '{0, 0, 0, 1, 0, 0, 0, 1};
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end

    // Reset held with every source requesting.
    force_all = 1;
    repeat (2) @(negedge clk);
    force_all = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) log_g[i] = -1;

    // Single source, fixed data.
    weight = {4{4'd1}};
    add_pkt(1, 4, 8'h0F);
    drain("single", 100);
    chk("single_pkts", log_n, 1);
    chk("single_src", log_g[0], 1);

    // Plain round robin, 2-beat packets on every source.
    do_reset(2);
    for (int p = 0; p < 3; p++) for (int s = 0; s < N; s++) add_pkt(s, 2, -1);
    drain("rr", 500);
    for (int i = 0; i < 5; i++) chk("rr_order", log_g[i], exp_rr[i]);

    // Weights 3:1 on two continuously valid sources.
    do_reset(2);
    weight = {4'd1, 4'd1, 4'd1, 4'd3};
    for (int p = 0; p < 8; p++) begin
      add_pkt(0, $urandom_range(1, 3), -1);
      add_pkt(1, $urandom_range(1, 3), -1);
    end
    drain("wgt", 800);
    for (int i = 0; i < 8; i++) chk("wgt_order", log_g[i], exp_w[i]);

    // Random gaps, sink backpressure and weights changing between rounds.
    do_reset(2);
    gate_pct = 60;
    rdy_pct  = 50;
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < N; s++) weight[s*WW +: WW] = WW'($urandom_range(3));
      for (int s = 0; s < N; s++)
        for (int p = 0; p < int'($urandom_range(4)); p++) add_pkt(s, $urandom_range(1, 4), -1);
      drain("rand", 3000);
    end
    gate_pct = 100;
    rdy_pct  = 100;

    // Reset in the middle of a packet must also return ptr to 0.
    do_reset(2);
    weight = {4{4'd1}};
    add_pkt(2, 1, -1);
    drain("pre_rst", 100);
    add_pkt(2, 5, -1);
    c = 0;
    while (beats_seen < 3 && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (c >= 50) chk("midrst_timeout", c, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    log_n = 0;
    for (int i = 0; i < 64; i++) log_g[i] = -1;
    add_pkt(1, 2, -1);
    add_pkt(3, 2, -1);
    drain("post_rst", 200);
    chk("post_rst_first", log_g[0], 1);
    chk("post_rst_second", log_g[1], 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_wrr_arbiter.md
# axis_wrr_arbiter

Packet-atomic, weighted round-robin arbiter that merges N AXI4-Stream byte sources onto one AXI4-Stream sink. Generalises the two-source A/B→K stream arbitration path to N requesters with per-port packet quotas, so a streaming source cannot starve its neighbours. It sits between the stream producers and the shared K-side consumer, and never splits a packet.

## Interface
- N, 4, number of requesters (≥2)
- DW, 8, tdata width per port
- WW, 4, weight width; weight = packets per turn
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- s_tvalid  in  N  per-source tvalid, bit i = source i
- s_tlast  in  N  per-source tlast
- s_tdata  in  N*DW  source i at [i*DW +: DW]
- s_tready  out  N  per-source tready
- weight  in  N*WW  quota of source i at [i*WW +: WW]; sampled only at grant
- m_tvalid  out  1  sink tvalid
- m_tlast  out  1  sink tlast
- m_tdata  out  DW  sink tdata
- m_tready  in  1  sink tready
- grant_id  out  clog2(N)  currently/last granted source
- busy  out  1  high while a packet is granted (state PKT)

## Operation
- FSM states: IDLE, PKT.
- IDLE: if any s_tvalid set, select the winner, register grant_id, go to PKT. If none set, stay in IDLE.
- Winner selection:
  - If credit > 0 and s_tvalid[grant_id] is set, re-grant grant_id.
  - Otherwise, pick the first set s_tvalid scanning from ptr upward with wrap N-1→0, then load credit = weight[winner]. A weight of 0 is treated as 1.
- PKT:
  - m_tvalid = s_tvalid[grant_id], m_tlast = s_tlast[grant_id], m_tdata = source grant_id's data.
  - s_tready[grant_id] = m_tready; all other s_tready bits are 0.
- End of packet (m_tvalid & m_tready & m_tlast):
  - credit decrements.
  - If credit reaches 0, ptr = grant_id+1 mod N.
  - FSM returns to IDLE.
- Outside PKT, m_tvalid = m_tlast = 0, m_tdata = 0, and s_tready = 0.
- The grant is held for the whole packet. A granted source dropping tvalid mid-packet stalls the sink (m_tvalid=0); the grant is not revoked. Other sources wait.
- Credit and ptr change only on a tlast handshake or a fresh grant.

## Timing
- Reset values: state IDLE, ptr 0, credit 0, grant_id 0, busy 0, m_tvalid 0, m_tlast 0, m_tdata 0, s_tready 0.
- Arbitration latency: a request seen in IDLE at edge k gives busy=1 and the first beat transferable in cycle k+1.
- Datapath is combinational passthrough in PKT: zero added data latency, no buffering.
- One mandatory IDLE bubble cycle after each tlast handshake, including back-to-back packets from the same source.
- Simultaneous requests: resolved by ptr order. Example: ptr=2, N=4, requests {0,3} → 3 wins.
- A weight change mid-turn has no effect until the next fresh grant.
- Reset asserted in PKT: the next edge forces reset values. The sink sees a truncated packet with no tlast; this is accepted behaviour.
- Single active source: served indefinitely at 1 bubble per packet; ptr still advances on credit exhaustion.

## Structure
- Package axis_arb_pkg holds:
  - state enum {IDLE, PKT}
  - default N/DW/WW constants
  - a clog2-derived index width constant
- Sub-module rr_picker (combinational): inputs req[N] and ptr; outputs any and idx. Implements the rotate-from-ptr priority encoder.
- Top holds the FSM, credit counter, ptr, grant register and output mux.

## Test plan
- Reset: hold reset 3 cycles with all s_tvalid=1 → all outputs 0, s_tready=0, grant_id=0, busy=0.
- Single source: source 1 only, 4-beat packet, tdata 8'h0F, m_tready=1 → first beat the cycle after request, m_tlast on beat 4, s_tready = 4'b0010 during packet, 1 idle cycle after.
- Round-robin: N=4, weights all 1, all sources send 2-beat packets continuously → grant order 0,1,2,3,0; no beat interleaving.
- Weighting: weight0=3, weight1=1, both continuously valid → grant order 0,0,0,1,0,0,0,1.
- Backpressure and stall: m_tready toggled 1/0 while the granted source drops tvalid for 2 cycles mid-packet; another source is valid meanwhile → grant unchanged, no data loss, beats in order, other source's s_tready=0 throughout.
- Mid-packet reset: assert reset after beat 2 of a 5-beat packet → next cycle outputs are at reset values; the next request is granted starting from ptr 0.
